if_id_queue: RTL
================

# if_id_queue

Instruction queue between the fetch stage and the decode stage. Captures each fetched instruction with its PC and PC+4, buffers up to DEPTH entries in program order, and presents the oldest entry to decode. Fetch uses the `full` output as its stall input. A branch-taken flush discards all buffered wrong-path instructions in one cycle.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- CW, 3, count width = log2(DEPTH)+1

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- push  in  1  fetch presents a valid instruction this cycle
- if_instruction  in  32  fetched instruction word
- if_pc  in  32  PC of fetched instruction
- if_pc_plus_4  in  32  PC+4 of fetched instruction
- pop  in  1  decode consumes the head entry this cycle
- flush  in  1  branch taken; discard all entries
- id_valid  out  1  head entry valid (queue non-empty)
- id_instruction  out  32  head instruction; 32'h0000_0000 (NOP) when empty
- id_pc  out  32  head PC; 0 when empty
- id_pc_plus_4  out  32  head PC+4; 0 when empty
- full  out  1  count == DEPTH; drives fetch stall
- count  out  CW  number of valid entries, 0..DEPTH

## Operation
- Storage: circular buffer of DEPTH entries of {instruction, pc, pc_plus_4}. Write pointer wr_ptr, read pointer rd_ptr, count register. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Push accepted iff push && !full && !flush:
  - write entry at wr_ptr
  - wr_ptr += 1
- Pop accepted iff pop && id_valid && !flush:
  - rd_ptr += 1
- Pop on empty is ignored; no pointer or count change.
- Push on full is ignored and the data is dropped. Fetch must already be stalled by `full`.
- `full` is computed from the registered count only; there is no same-cycle pop bypass. A push while full is rejected even if a pop occurs in the same cycle.
- Count update:
  - +1 on accepted push only
  - −1 on accepted pop only
  - unchanged when both are accepted
- Simultaneous push and pop on empty: the push is accepted and the pop is ignored. The new entry is not visible until the next cycle.
- Flush has highest priority:
  - count, wr_ptr and rd_ptr go to 0
  - same-cycle push and pop are discarded
  - takes effect at that clock edge
- Head outputs are driven combinationally from the entry at rd_ptr, gated to zero when count == 0.
- Flush and empty queue both present a NOP with id_valid = 0. Decode must treat id_valid = 0 as a bubble.

## Timing
- Reset (reset = 0, asynchronous, any time):
  - count = 0, wr_ptr = 0, rd_ptr = 0
  - id_valid = 0, full = 0
  - id_instruction = id_pc = id_pc_plus_4 = 0
  - Storage contents need not be cleared.
- Reset deassertion is synchronized externally; the first accepted push is the first rising edge with reset = 1.
- Latency: an entry pushed at edge N is visible on the id_* outputs after edge N (cycle N+1) when the queue was empty.
- Throughput: one push and one pop per cycle sustained.
- Full boundary: after DEPTH pushes with no pops, full = 1 in the following cycle. After one pop, full = 0 the next cycle.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no gap. FIFO order is preserved across the wrap.
- Flush at edge N: id_valid = 0 and count = 0 in cycle N+1. A push at edge N+1 is accepted normally.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.

## Test plan
- Reset, then push pc 0x00, 0x04, 0x08 (instr 0xE3A01005, 0xE2811001, 0xE0812002) with pop = 0 -> count = 3. Then pop ×3 -> outputs appear in order, count = 0, id_valid = 0, id_instruction = 0.
- Push 4 entries with DEPTH = 4 -> full = 1. 5th push of 0xDEADBEEF -> dropped, count stays 4. Pop+push in the same cycle while full -> push rejected, count = 3.
- Continuous push+pop for 10 cycles with pc = 0x00..0x24 -> count steady at 1 after the first cycle, outputs in order, pointers wrap with no duplicates or gaps.
- Fill 3 entries, assert flush with push = 1 and pop = 1 -> next cycle count = 0, id_valid = 0. The following push of pc 0x80 appears at the head one cycle later.
- Pop on empty for 3 cycles -> count stays 0, no underflow, id_* = 0.
- Assert reset asynchronously between clock edges with count = 2 -> count = 0, id_valid = 0, full = 0 immediately. Pushes resume correctly after release.

Source files
------------

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
// Instruction queue between fetch and decode. Each fetched instruction is
// stored with its PC and PC+4 in a DEPTH-entry circular buffer and is handed
// to decode in program order. A branch-taken flush empties the queue in a
// single cycle.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   push            fetch offers an instruction this cycle
//   if_instruction  fetched instruction word
//   if_pc           PC of the fetched instruction
//   if_pc_plus_4    PC+4 of the fetched instruction
//   pop             decode consumes the head entry this cycle
//   flush           branch taken: discard every buffered entry
//   id_valid        head entry valid (queue non-empty)
//   id_instruction  head instruction, NOP (0) when empty
//   id_pc           head PC, 0 when empty
//   id_pc_plus_4    head PC+4, 0 when empty
//   full            queue holds DEPTH entries (fetch stall)
//   count           number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [31:0]   if_instruction,
    input  logic [31:0]   if_pc,
    input  logic [31:0]   if_pc_plus_4,
    input  logic          pop,
    input  logic          flush,
    output logic          id_valid,
    output logic [31:0]   id_instruction,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_pc_plus_4,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   r_instr_mem [DEPTH];
    logic [31:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_pc4_mem   [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_not_empty;
    logic          w_full;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Occupancy flags come from the registered count only (no pop bypass on full).
    always_comb begin
        w_not_empty = (r_count != {CW{1'b0}});
        w_full      = (r_count == CW'(DEPTH));
    end

    // Accept qualifiers: flush overrides both, pop on empty and push on full are dropped.
    always_comb begin
        w_push_ok = push && !w_full && !flush;
        w_pop_ok  = pop && w_not_empty && !flush;
    end

    // Entry storage; contents are left stale on reset because count gates the outputs.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_instr_mem[r_wr_ptr] <= if_instruction;
            r_pc_mem[r_wr_ptr]    <= if_pc;
            r_pc4_mem[r_wr_ptr]   <= if_pc_plus_4;
        end
    end

    // Write pointer: advances on an accepted push, cleared by flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= {PW{1'b0}};
        end else if (flush) begin
            r_wr_ptr <= {PW{1'b0}};
        end else if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
        end else begin
            r_wr_ptr <= r_wr_ptr;
        end
    end

    // Read pointer: advances on an accepted pop, cleared by flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= {PW{1'b0}};
        end else if (flush) begin
            r_rd_ptr <= {PW{1'b0}};
        end else if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
        end else begin
            r_rd_ptr <= r_rd_ptr;
        end
    end

    // Occupancy count: a simultaneous accepted push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= {CW{1'b0}};
        end else if (flush) begin
            r_count <= {CW{1'b0}};
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head presentation: the entry at rd_ptr, forced to a NOP bubble when empty.
    always_comb begin
        id_valid       = w_not_empty;
        full           = w_full;
        count          = r_count;
        id_instruction = 32'h0000_0000;
        id_pc          = 32'h0000_0000;
        id_pc_plus_4   = 32'h0000_0000;
        if (w_not_empty) begin
            id_instruction = r_instr_mem[r_rd_ptr];
            id_pc          = r_pc_mem[r_rd_ptr];
            id_pc_plus_4   = r_pc4_mem[r_rd_ptr];
        end else begin
            id_instruction = 32'h0000_0000;
            id_pc          = 32'h0000_0000;
            id_pc_plus_4   = 32'h0000_0000;
        end
    end

endmodule
